sdram_arbiter: RTL and testbench

Shares the single SDRAM controller port between three requesters: refresh strobes, the Z80 memory port (18-bit address, byte data) and a 16-bit loader port used for SD-card ROM/tape loading. It sits between `main`/loader logic and `sdram`. It turns requests into one-cycle command strobes on the controller, serialises them with fixed priority, and returns read data and completions to the requester that was granted.

---
 rtl/sdram_arbiter.sv | 159 +++++++++++++++
 tb/tb_sdram_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: serialises refresh, CPU and loader requests onto one SDRAM controller port.
// Optional SDRAM_ARB_AGING_EN lets a long-waiting loader request overtake the CPU.
`timescale 1ns/1ps
module sdram_arbiter #(
    parameter int CMD_CYCLES  = 8,
    parameter int LD_WAIT_MAX = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ready,
    input  logic        rfsh,
    input  logic        cpuRd,
    input  logic        cpuWr,
    input  logic [17:0] cpuA,
    input  logic [7:0]  cpuD,
    output logic [7:0]  cpuQ,
    input  logic        ldReq,
    input  logic        ldWe,
    input  logic [23:0] ldA,
    input  logic [15:0] ldD,
    output logic [15:0] ldQ,
    output logic        ldAck,
    output logic        sdrRf,
    output logic        sdrRd,
    output logic        sdrWr,
    output logic [23:0] sdrA,
    output logic [15:0] sdrD,
    input  logic [15:0] sdrQ,
    output logic        ovr
);
    localparam int CW = $clog2(CMD_CYCLES);
    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;
    typedef enum logic [1:0] {G_RF, G_CPU, G_LD} gnt_t;
    state_t        state_q, state_d;
    gnt_t          gnt_q, gnt_d;
    logic          rd_op_q, rd_op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rf_pend_q, rf_pend_d, cpu_pend_q, cpu_pend_d;
    logic          cpu_we_q, cpu_we_d;
    logic [17:0]   cpu_a_q, cpu_a_d;
    logic [7:0]    cpu_d_q, cpu_d_d;
    logic          ovr_q, ovr_d;
    logic          rf_q, rf_d, rd_q, rd_d, wr_q, wr_d;
    logic [23:0]   sdr_a_q, sdr_a_d;
    logic [15:0]   sdr_d_q, sdr_d_d;
    logic [7:0]    cpu_rdata_q, cpu_rdata_d;
    logic [15:0]   ld_rdata_q, ld_rdata_d;
    logic          ld_ack_q, ld_ack_d;
    logic          aged, go, cpu_stb, take_rf, take_cpu, take_ld;
`ifdef SDRAM_ARB_AGING_EN
    localparam int WW = $clog2(LD_WAIT_MAX + 1);
    logic [WW-1:0] wait_q, wait_d;
    always_comb wait_d = (take_ld || !ldReq) ? '0 : (wait_q == WW'(LD_WAIT_MAX)) ? wait_q : wait_q + 1'b1;
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) wait_q <= '0;
        else          wait_q <= wait_d;
    assign aged = wait_q == WW'(LD_WAIT_MAX);
`else
    assign aged = LD_WAIT_MAX < 0;
`endif
    always_comb begin
        go       = (state_q == IDLE) && ready;
        cpu_stb  = cpuRd | cpuWr;
        take_rf  = go && rf_pend_q;
        // the ack cycle is masked so a loader dropping ldReq right after ldAck is not re-granted
        take_ld  = go && !rf_pend_q && ldReq && !ld_ack_q && (aged || !cpu_pend_q);
        take_cpu = go && !rf_pend_q && cpu_pend_q && !take_ld;
        state_d     = state_q;
        gnt_d       = gnt_q;
        rd_op_d     = rd_op_q;
        cnt_d       = cnt_q;
        rf_pend_d   = rfsh | (rf_pend_q & ~take_rf);
        cpu_pend_d  = cpu_stb | (cpu_pend_q & ~take_cpu);
        cpu_we_d    = cpu_stb ? cpuWr : cpu_we_q;
        cpu_a_d     = cpu_stb ? cpuA : cpu_a_q;
        cpu_d_d     = cpu_stb ? cpuD : cpu_d_q;
        ovr_d       = ovr_q | (rfsh & rf_pend_q & ~take_rf) | (cpu_stb & cpu_pend_q & ~take_cpu);
        rf_d        = take_rf;
        rd_d        = (take_cpu & ~cpu_we_q) | (take_ld & ~ldWe);
        wr_d        = (take_cpu & cpu_we_q) | (take_ld & ldWe);
        sdr_a_d     = sdr_a_q;
        sdr_d_d     = sdr_d_q;
        cpu_rdata_d = cpu_rdata_q;
        ld_rdata_d  = ld_rdata_q;
        ld_ack_d    = 1'b0;
        case (state_q)
            IDLE: if (take_rf || take_cpu || take_ld) begin
                state_d = ISSUE;
                gnt_d   = take_rf ? G_RF : take_cpu ? G_CPU : G_LD;
                rd_op_d = rd_d;
                sdr_a_d = take_cpu ? {6'd0, cpu_a_q} : take_ld ? ldA : '0;
                sdr_d_d = take_cpu ? {2{cpu_d_q}} : take_ld ? ldD : '0;
            end
            ISSUE: begin
                state_d = BUSY;
                cnt_d   = '0;
            end
            BUSY: if (cnt_q == CW'(CMD_CYCLES - 2)) begin
                state_d     = IDLE;
                cpu_rdata_d = (gnt_q == G_CPU && rd_op_q) ? sdrQ[7:0] : cpu_rdata_q;
                ld_rdata_d  = (gnt_q == G_LD && rd_op_q) ? sdrQ : ld_rdata_q;
                ld_ack_d    = gnt_q == G_LD;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            gnt_q       <= G_RF;
            rd_op_q     <= 1'b0;
            cnt_q       <= '0;
            rf_pend_q   <= 1'b0;
            cpu_pend_q  <= 1'b0;
            cpu_we_q    <= 1'b0;
            cpu_a_q     <= '0;
            cpu_d_q     <= '0;
            ovr_q       <= 1'b0;
            rf_q        <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            sdr_a_q     <= '0;
            sdr_d_q     <= '0;
            cpu_rdata_q <= '0;
            ld_rdata_q  <= '0;
            ld_ack_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rd_op_q     <= rd_op_d;
            cnt_q       <= cnt_d;
            rf_pend_q   <= rf_pend_d;
            cpu_pend_q  <= cpu_pend_d;
            cpu_we_q    <= cpu_we_d;
            cpu_a_q     <= cpu_a_d;
            cpu_d_q     <= cpu_d_d;
            ovr_q       <= ovr_d;
            rf_q        <= rf_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            sdr_a_q     <= sdr_a_d;
            sdr_d_q     <= sdr_d_d;
            cpu_rdata_q <= cpu_rdata_d;
            ld_rdata_q  <= ld_rdata_d;
            ld_ack_q    <= ld_ack_d;
        end
    end
    assign sdrRf = rf_q;
    assign sdrRd = rd_q;
    assign sdrWr = wr_q;
    assign sdrA  = sdr_a_q;
    assign sdrD  = sdr_d_q;
    assign cpuQ  = cpu_rdata_q;
    assign ldQ   = ld_rdata_q;
    assign ldAck = ld_ack_q;
    assign ovr   = ovr_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed and randomized checks of sdram_arbiter against a memory-level controller model.
`timescale 1ns/1ps
module tb_sdram_arbiter;
    localparam int CMD_CYCLES  = 8;
    localparam int LD_WAIT_MAX = 64;
    logic        clock = 1'b0, reset_n = 1'b0, ready = 1'b1;
    logic        rfsh = 1'b0, cpuRd = 1'b0, cpuWr = 1'b0;
    logic [17:0] cpuA = '0;
    logic [7:0]  cpuD = '0;
    logic        ldReq = 1'b0, ldWe = 1'b0;
    logic [23:0] ldA = '0;
    logic [15:0] ldD = '0;
    logic [15:0] sdrQ = '0;
    logic [7:0]  cpuQ;
    logic [15:0] ldQ, sdrD;
    logic [23:0] sdrA;
    logic        ldAck, sdrRf, sdrRd, sdrWr, ovr;
    sdram_arbiter #(.CMD_CYCLES(CMD_CYCLES), .LD_WAIT_MAX(LD_WAIT_MAX)) dut (
        .clock(clock), .reset_n(reset_n), .ready(ready), .rfsh(rfsh),
        .cpuRd(cpuRd), .cpuWr(cpuWr), .cpuA(cpuA), .cpuD(cpuD), .cpuQ(cpuQ),
        .ldReq(ldReq), .ldWe(ldWe), .ldA(ldA), .ldD(ldD), .ldQ(ldQ), .ldAck(ldAck),
        .sdrRf(sdrRf), .sdrRd(sdrRd), .sdrWr(sdrWr), .sdrA(sdrA), .sdrD(sdrD),
        .sdrQ(sdrQ), .ovr(ovr)
    );
    always #5 clock = ~clock;
    int n_chk = 0, n_fail = 0;
    logic [15:0] ctl_mem [logic [23:0]];
    logic [7:0]  ref_mem [logic [17:0]];
    int          q_cnt = 0;
    logic [23:0] q_addr = '0;
    // controller model: garbage on sdrQ after a read strobe until the data becomes valid
    always @(posedge clock) begin
        if (sdrWr) ctl_mem[sdrA] = sdrD;
        if (sdrRd) begin
            q_addr = sdrA;
            q_cnt  = 1;
            sdrQ  <= 16'($urandom);
        end else if (q_cnt > 0) begin
            q_cnt++;
            if (q_cnt == CMD_CYCLES - 1) begin
                sdrQ <= ctl_mem.exists(q_addr) ? ctl_mem[q_addr] : 16'h0;
                q_cnt = 0;
            end
        end
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clock);
        #1;
        rfsh  = 1'b0;
        cpuRd = 1'b0;
        cpuWr = 1'b0;
    endtask
    task automatic ticks(input int n);
        repeat (n) tick();
    endtask
    task automatic cpu_op(input logic we, input logic [17:0] a, input logic [7:0] d);
        cpuRd = !we;
        cpuWr = we;
        cpuA  = a;
        cpuD  = d;
    endtask
    task automatic wait_cmd(output int n);
        n = 0;
        do begin tick(); n++; end while (!(sdrRf || sdrRd || sdrWr) && n < 60);
    endtask
    task automatic wait_ack(output int n);
        n = 0;
        do begin tick(); n++; end while (!ldAck && n < 60);
    endtask
    task automatic count_cmds(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            tick();
            if (sdrRf || sdrRd || sdrWr) n++;
        end
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int n, granted, acks;
        logic we, rf;
        logic [17:0] a;
        logic [7:0] d;
        tick();
        chk("rst_cmd", {sdrRf, sdrRd, sdrWr}, 0);
        chk("rst_a", sdrA, 0);
        chk("rst_d", sdrD, 0);
        chk("rst_cpuq", cpuQ, 0);
        chk("rst_ldq", ldQ, 0);
        chk("rst_ack", ldAck, 0);
        chk("rst_ovr", ovr, 0);
        reset_n = 1'b1;
        ticks(2);
        cpu_op(1'b1, 18'h1234, 8'hA5);
        wait_cmd(n);
        chk("wr_lat", n, 2);
        chk("wr_kind", {sdrRf, sdrRd, sdrWr}, 3'b001);
        chk("wr_a", sdrA, 24'h001234);
        chk("wr_d", sdrD, 16'hA5A5);
        chk("wr_ovr", ovr, 0);
        tick();
        chk("wr_pulse", sdrWr, 0);
        ticks(CMD_CYCLES - 1);
        ctl_mem[24'h000456] = 16'h5A3C;
        cpu_op(1'b0, 18'h456, 8'h00);
        wait_cmd(n);
        chk("rd_lat", n, 2);
        chk("rd_kind", {sdrRf, sdrRd, sdrWr}, 3'b010);
        ticks(CMD_CYCLES - 1);
        chk("rd_early", cpuQ, 0);
        tick();
        chk("rd_q", cpuQ, 8'h3C);
        cpu_op(1'b1, 18'h999, 8'h77);
        wait_cmd(n);
        ticks(CMD_CYCLES);
        chk("rd_hold", cpuQ, 8'h3C);
        rfsh = 1'b1;
        cpu_op(1'b0, 18'h777, 8'h00);
        wait_cmd(n);
        chk("rf_lat", n, 2);
        chk("rf_kind", {sdrRf, sdrRd, sdrWr}, 3'b100);
        wait_cmd(n);
        chk("rf_gap", n, CMD_CYCLES + 1);
        chk("rf_cpu_kind", {sdrRf, sdrRd, sdrWr}, 3'b010);
        chk("rf_cpu_a", sdrA, 24'h000777);
        ticks(CMD_CYCLES);
        ctl_mem[24'h080000] = 16'hBEEF;
        ldReq = 1'b1; ldWe = 1'b0; ldA = 24'h080000; ldD = 16'h0;
        wait_cmd(n);
        chk("ld_lat", n, 1);
        chk("ld_kind", {sdrRf, sdrRd, sdrWr}, 3'b010);
        chk("ld_a", sdrA, 24'h080000);
        wait_ack(n);
        chk("ld_ack_lat", n, CMD_CYCLES);
        chk("ld_q", ldQ, 16'hBEEF);
        ldReq = 1'b0;
        tick();
        chk("ld_ack_w", ldAck, 0);
        count_cmds(11, n);
        chk("ld_once", n, 0);
        ctl_mem[24'h080000] = 16'h1357;
        ready = 1'b0;
        ldReq = 1'b1;
        count_cmds(20, n);
        chk("nrdy_idle", n, 0);
        ready = 1'b1;
        wait_cmd(n);
        chk("nrdy_lat", n, 1);
        wait_ack(n);
        chk("nrdy_ack_lat", n, CMD_CYCLES);
        chk("nrdy_q", ldQ, 16'h1357);
        ldReq = 1'b0;
        ticks(2);
        ldReq = 1'b1; ldWe = 1'b1; ldA = 24'h0F0000; ldD = 16'h4242;
        wait_cmd(n);
        chk("ovr_ldwr", {sdrRd, sdrWr}, 2'b01);
        chk("ovr_pre", ovr, 0);
        cpu_op(1'b1, 18'h111, 8'h11);
        ticks(3);
        cpu_op(1'b1, 18'h222, 8'h22);
        wait_ack(n);
        ldReq = 1'b0;
        wait_cmd(n);
        chk("ovr_a", sdrA, 24'h000222);
        chk("ovr_d", sdrD, 16'h2222);
        chk("ovr_flag", ovr, 1);
        count_cmds(20, n);
        chk("ovr_single", n, 0);
        chk("ovr_lost", ctl_mem.exists(24'h000111), 0);
        ctl_mem[24'h0A0000] = 16'h7777;
        ldReq = 1'b1; ldWe = 1'b0; ldA = 24'h0A0000;
        wait_cmd(n);
        ticks(3);
        reset_n = 1'b0;
        #1;
        chk("ar_a", sdrA, 0);
        chk("ar_ldq", ldQ, 0);
        chk("ar_ack", ldAck, 0);
        chk("ar_ovr", ovr, 0);
        ldReq = 1'b0;
        tick();
        reset_n = 1'b1;
        acks = 0;
        repeat (15) begin
            tick();
            if (ldAck) acks++;
        end
        chk("ar_noack", acks, 0);
        cpu_op(1'b1, 18'h300, 8'h00);
        tick();
        ldReq = 1'b1; ldWe = 1'b1; ldA = 24'hABCDEF; ldD = 16'h5555;
        granted = -1;
        for (int c = 1; c < 160; c++) begin
            if (c % 9 == 0) cpu_op(1'b1, 18'h300 + 18'(c), 8'(c));
            tick();
            if (granted < 0 && sdrWr && sdrA == 24'hABCDEF) granted = c + 1;
            if (ldAck) ldReq = 1'b0;
        end
        ldReq = 1'b0;
`ifdef SDRAM_ARB_AGING_EN
        chk("aging", granted > 0 && granted <= LD_WAIT_MAX + CMD_CYCLES + 3, 1);
`else
        chk("starve", granted < 0, 1);
`endif
        ticks(20);
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 1));
            a  = 18'($urandom_range(0, 15));
            d  = 8'($urandom);
            rf = $urandom_range(0, 3) == 0;
            rfsh = rf;
            cpu_op(we, a, d);
            n = 0;
            do begin tick(); n++; end while (!(sdrRd || sdrWr) && n < 40);
            chk("rnd_lat", n, rf ? CMD_CYCLES + 3 : 2);
            chk("rnd_kind", {sdrRd, sdrWr}, we ? 2'b01 : 2'b10);
            chk("rnd_a", sdrA, {6'd0, a});
            if (we) begin
                chk("rnd_d", sdrD, {d, d});
                ref_mem[a] = d;
            end
            ticks(CMD_CYCLES);
            if (!we) chk("rnd_q", cpuQ, ref_mem.exists(a) ? ref_mem[a] : 8'h00);
            ticks($urandom_range(0, 2));
        end
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
